// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the 7-segment scan decoder.
//   - Segment bit order: seg[6]=a ... seg[0]=g, all segments active high.
//   - Ten standard decimal glyphs, the two tail-less alternates for 6 and 9,
//     and the blank pattern.
//   - FSM state type used by seg7_scan_decoder.
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Bit positions of each segment inside the 7-bit seg vector
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Standard glyphs, ordered abcdefg
    localparam logic [6:0] SEG7_GLYPH_0 = 7'b1111110;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'b0110000;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'b1101101;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'b1111001;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'b0110011;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'b1011011;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'b1011111;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'b1110000;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'b1111111;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'b1111011;

    // Tail-less variants some drivers emit for 6 (no a) and 9 (no d)
    localparam logic [6:0] SEG7_GLYPH_6_ALT = 7'b0011111;
    localparam logic [6:0] SEG7_GLYPH_9_ALT = 7'b1110011;

    // All segments dark
    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    // Scan FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundle between a scanned 7-segment display bus and its decoder.
//   seg         : 7 segment lines, abcdefg, active high (display side drives)
//   an          : DIGITS one-hot digit selects (display side drives)
//   bcd         : 4*DIGITS decoded digits, digit i in bcd[4i+3:4i]
//   digit_valid : DIGITS per-digit valid flags
//   frame_done  : one-cycle pulse when every position has been captured
//   pattern_err : one-cycle pulse on capture of an illegal pattern
//   err_digit   : position of the last illegal capture
// Modports: master = display/observer side, slave = decoder.
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_done;
    logic                pattern_err;
    logic [2:0]          err_digit;

    modport master (
        output seg, an,
        input  bcd, digit_valid, frame_done, pattern_err, err_digit
    );

    modport slave (
        input  seg, an,
        output bcd, digit_valid, frame_done, pattern_err, err_digit
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational lookup from a 7-bit abcdefg pattern to a BCD digit.
//   seg   in  7 : segment pattern, seg[6]=a ... seg[0]=g
//   legal out 1 : pattern is a recognised decimal glyph
//   blank out 1 : pattern is all segments dark
//   bcd   out 4 : decoded value (0 when not legal)
// Build option: SEG7_ALT_GLYPH_EN also accepts the tail-less 6 and 9.
// -----------------------------------------------------------------------------
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    // Pattern lookup; anything not listed is illegal
    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        bcd   = 4'd0;
        case (seg)
            SEG7_GLYPH_0: bcd = 4'd0;
            SEG7_GLYPH_1: bcd = 4'd1;
            SEG7_GLYPH_2: bcd = 4'd2;
            SEG7_GLYPH_3: bcd = 4'd3;
            SEG7_GLYPH_4: bcd = 4'd4;
            SEG7_GLYPH_5: bcd = 4'd5;
            SEG7_GLYPH_6: bcd = 4'd6;
            SEG7_GLYPH_7: bcd = 4'd7;
            SEG7_GLYPH_8: bcd = 4'd8;
            SEG7_GLYPH_9: bcd = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
            SEG7_GLYPH_6_ALT: bcd = 4'd6;
            SEG7_GLYPH_9_ALT: bcd = 4'd9;
`endif
            SEG7_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: begin
                legal = 1'b0;
                blank = 1'b0;
                bcd   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Receive-side decoder for a multiplexed 7-segment display bus. seg/an are
// synchronised, each one-hot digit pattern must stay unchanged for
// STABLE_CYCLES synchronised samples, then it is decoded into a per-digit BCD
// register with a valid flag. A frame mask tracks which positions have been
// captured and pulses frame_done once all have been seen.
//   clk   in : system clock, rising edge
//   reset in : asynchronous, active-high reset
//   bus       : seg7_scan_decoder_if.slave (seg/an in, decoded results out)
// Parameters: DIGITS (1..8), STABLE_CYCLES (>=1).
// Build option: SEG7_ALT_GLYPH_EN (handled in seg7_glyph_decode).
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    seg7_scan_decoder_if.slave          bus
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    // Synchroniser stages and the previous synchronised sample
    logic [6:0]        seg_s1_q, seg_s2_q, seg_prev_q;
    logic [DIGITS-1:0] an_s1_q, an_s2_q, an_prev_q;

    seg7_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                frame_done_q, frame_done_d;
    logic                pattern_err_q, pattern_err_d;
    logic [2:0]          err_digit_q, err_digit_d;

    logic                an_onehot_s;
    logic                changed_s;
    logic                capture_s;
    logic [DIGITS-1:0]   mask_next_s;
    logic                dec_legal_s;
    logic                dec_blank_s;
    logic [3:0]          dec_bcd_s;

    seg7_glyph_decode u_decode (
        .seg   (seg_s2_q),
        .legal (dec_legal_s),
        .blank (dec_blank_s),
        .bcd   (dec_bcd_s)
    );

    // Two-flop synchronisers plus one more stage for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1_q   <= 7'd0;
            seg_s2_q   <= 7'd0;
            seg_prev_q <= 7'd0;
            an_s1_q    <= '0;
            an_s2_q    <= '0;
            an_prev_q  <= '0;
        end else begin
            seg_s1_q   <= bus.seg;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            an_s1_q    <= bus.an;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
        end
    end

    // Classify the current synchronised sample
    always_comb begin
        an_onehot_s = (an_s2_q != '0) && ((an_s2_q & (an_s2_q - AN_ONE)) == '0);
        changed_s   = (seg_s2_q != seg_prev_q) || (an_s2_q != an_prev_q);
    end

    // Scan FSM next state and stability counter (saturating)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        if (!an_onehot_s) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
                SETTLE: begin
                    if (changed_s) begin
                        cnt_d = CNT_ONE;
                    end else if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                CAPTURED: begin
                    if (changed_s) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = CAPTURED;
                        cnt_d   = cnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            // With STABLE_CYCLES=1 the first stable sample already captures
            if ((state_d == SETTLE) && (cnt_d >= CNT_MAX)) begin
                capture_s = 1'b1;
                state_d   = CAPTURED;
            end else begin
                capture_s = 1'b0;
            end
        end
    end

    // Capture results: digit registers, error report and frame mask
    always_comb begin
        bcd_d         = bcd_q;
        valid_d       = valid_q;
        mask_d        = mask_q;
        err_digit_d   = err_digit_q;
        frame_done_d  = 1'b0;
        pattern_err_d = 1'b0;
        mask_next_s   = mask_q | an_s2_q;
        if (capture_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (an_s2_q[i]) begin
                    if (dec_legal_s) begin
                        bcd_d[4*i +: 4] = dec_bcd_s;
                        valid_d[i]      = 1'b1;
                    end else if (dec_blank_s) begin
                        valid_d[i]      = 1'b0;
                    end else begin
                        valid_d[i]      = 1'b0;
                        pattern_err_d   = 1'b1;
                        err_digit_d     = 3'(i);
                    end
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end
            // Completing capture pulses and restarts the mask
            if (&mask_next_s) begin
                frame_done_d = 1'b1;
                mask_d       = '0;
            end else begin
                mask_d       = mask_next_s;
            end
        end else begin
            mask_d = mask_q;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bcd_q         <= '0;
            valid_q       <= '0;
            mask_q        <= '0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            err_digit_q   <= 3'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bcd_q         <= bcd_d;
            valid_q       <= valid_d;
            mask_q        <= mask_d;
            frame_done_q  <= frame_done_d;
            pattern_err_q <= pattern_err_d;
            err_digit_q   <= err_digit_d;
        end
    end

    assign bus.bcd         = bcd_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Scoreboard bench: every input hold is fed to a behavioural model working at
// the level of "held segments"; expected output events (with the edge on which
// they must appear) are queued and a negedge monitor pops and compares them
// whenever the decoder's outputs change or pulse.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic        fd;
        logic        pe;
        logic [2:0]  ed;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t exp_q[$];

    // behavioural model state
    int         m_dig [DIGITS];
    logic [3:0] m_valid;
    logic [3:0] m_mask;
    logic [2:0] m_err;
    logic [3:0] prev_a;
    logic [6:0] prev_s;

    // monitor state
    logic [15:0] last_bcd;
    logic [3:0]  last_valid;
    logic [2:0]  last_err;

    logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic void tb_decode(input logic [6:0] s, output bit legal, output bit blank, output int val);
        legal = 1'b0;
        blank = (s == 7'd0);
        val   = 0;
        for (int j = 0; j < 10; j++) begin
            if (s == glyph[j]) begin
                legal = 1'b1;
                val   = j;
            end
        end
`ifdef SEG7_ALT_GLYPH_EN
        if (s == 7'b0011111) begin legal = 1'b1; val = 6; end
        if (s == 7'b1110011) begin legal = 1'b1; val = 9; end
`endif
    endfunction

    function automatic logic [15:0] model_bcd();
        logic [15:0] b;
        for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'(m_dig[i]);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
        m_valid = 4'd0;
        m_mask  = 4'd0;
        m_err   = 3'd0;
        prev_a  = 4'd0;
        prev_s  = 7'd0;
    endtask

    // One capture of pattern s at the position selected by a
    task automatic model_capture(input logic [3:0] a, input logic [6:0] s, input int when);
        int          idx;
        bit          legal, blank, fd, pe;
        int          val;
        logic [15:0] old_bcd;
        logic [3:0]  old_valid;
        exp_t        e;
        idx       = $clog2(a);
        old_bcd   = model_bcd();
        old_valid = m_valid;
        fd        = 1'b0;
        pe        = 1'b0;
        tb_decode(s, legal, blank, val);
        if (legal) begin
            m_dig[idx]   = val;
            m_valid[idx] = 1'b1;
        end else begin
            m_valid[idx] = 1'b0;
            if (!blank) begin
                pe    = 1'b1;
                m_err = 3'(idx);
            end
        end
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            fd     = 1'b1;
            m_mask = 4'd0;
        end
        if (fd || pe || model_bcd() != old_bcd || m_valid != old_valid) begin
            e.cyc = when; e.bcd = model_bcd(); e.valid = m_valid;
            e.fd = fd; e.pe = pe; e.ed = m_err;
            exp_q.push_back(e);
        end
    endtask

    // Hold raw (a, s) for len sampling edges; called just after a rising edge
    task automatic seg_hold(input logic [3:0] a, input logic [6:0] s, input int len);
        if ($countones(a) == 1 && len >= STABLE && !(a == prev_a && s == prev_s))
            model_capture(a, s, cyc + STABLE + 2);
        prev_a = a;
        prev_s = s;
        bus.an  = a;
        bus.seg = s;
        repeat (len) @(posedge clk);
        #1;
    endtask

    // Monitor: every output change or pulse must match the next queued event
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_bcd   = 16'd0;
            last_valid = 4'd0;
            last_err   = 3'd0;
        end else if (bus.frame_done || bus.pattern_err || bus.bcd !== last_bcd ||
                     bus.digit_valid !== last_valid || bus.err_digit !== last_err) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_event: got bcd=%h valid=%b fd=%b pe=%b ed=%0d at cyc %0d, want no event",
                         bus.bcd, bus.digit_valid, bus.frame_done, bus.pattern_err, bus.err_digit, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("bcd", {16'd0, bus.bcd}, {16'd0, e.bcd});
                check("digit_valid", {28'd0, bus.digit_valid}, {28'd0, e.valid});
                check("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
                check("pattern_err", {31'd0, bus.pattern_err}, {31'd0, e.pe});
                check("err_digit", {29'd0, bus.err_digit}, {29'd0, e.ed});
            end
            last_bcd   = bus.bcd;
            last_valid = bus.digit_valid;
            last_err   = bus.err_digit;
        end
    end

    initial begin
        logic [3:0] a;
        logic [6:0] s;
        int         len, r;
        model_reset();
        bus.an  = 4'd0;
        bus.seg = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd", {16'd0, bus.bcd}, 32'd0);
        check("reset_valid", {28'd0, bus.digit_valid}, 32'd0);
        reset = 1'b0;

        // Scan glyphs 1..4 across the four positions
        seg_hold(4'b0001, 7'b0110000, 8);
        seg_hold(4'b0010, 7'b1101101, 8);
        seg_hold(4'b0100, 7'b1111001, 8);
        seg_hold(4'b1000, 7'b0110011, 8);
        check("scan_bcd", {16'd0, bus.bcd}, 32'h4321);
        check("scan_valid", {28'd0, bus.digit_valid}, 32'hF);

        // Short 0 then stable 8 on digit 0
        seg_hold(4'b0001, 7'b1111110, 3);
        seg_hold(4'b0001, 7'b1111111, 6);
        check("settle_bcd", {16'd0, bus.bcd}, 32'h4328);

        // Two selects at once: nothing may happen
        seg_hold(4'b0110, 7'b1111111, 10);

        // Illegal pattern on digit 2
        seg_hold(4'b0100, 7'b1001001, 8);
        check("illegal_valid", {28'd0, bus.digit_valid}, 32'hB);
        check("illegal_err_digit", {29'd0, bus.err_digit}, 32'd2);
        check("illegal_bcd", {16'd0, bus.bcd}, 32'h4328);

        // Tail-less 6 on digit 0
        seg_hold(4'b0001, 7'b0011111, 8);
`ifdef SEG7_ALT_GLYPH_EN
        check("alt6_bcd", {16'd0, bus.bcd}, 32'h4326);
        check("alt6_valid", {28'd0, bus.digit_valid}, 32'hB);
`else
        check("alt6_valid", {28'd0, bus.digit_valid}, 32'hA);
        check("alt6_err_digit", {29'd0, bus.err_digit}, 32'd0);
`endif

        // Asynchronous reset in the middle of a settle
        check("pending_before_reset", 32'(exp_q.size()), 32'd0);
        bus.an  = 4'b0001;
        bus.seg = 7'b1111111;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_bcd", {16'd0, bus.bcd}, 32'd0);
        check("async_rst_valid", {28'd0, bus.digit_valid}, 32'd0);
        check("async_rst_fd", {31'd0, bus.frame_done}, 32'd0);
        check("async_rst_pe", {31'd0, bus.pattern_err}, 32'd0);
        check("async_rst_ed", {29'd0, bus.err_digit}, 32'd0);
        bus.an  = 4'd0;
        bus.seg = 7'd0;
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        seg_hold(4'b0001, 7'b1111111, 8);

        // Randomised holds
        for (int n = 0; n < 300; n++) begin
            do begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      a = 4'd0;
                else if (r == 1) a = 4'($urandom_range(0, 15));
                else             a = 4'b0001 << $urandom_range(0, 3);
                r = int'($urandom_range(0, 9));
                if (r < 6)       s = glyph[$urandom_range(0, 9)];
                else if (r == 6) s = 7'd0;
                else if (r == 7) s = ($urandom_range(0, 1) == 0) ? 7'b0011111 : 7'b1110011;
                else             s = 7'($urandom_range(0, 127));
                len = int'($urandom_range(1, 8));
            end while (a == prev_a && s == prev_s);
            seg_hold(a, s, len);
        end

        // Drain outstanding events with a bounded wait
        bus.an = 4'd0;
        prev_a = 4'd0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side decoder for multiplexed 7-segment display buses. It samples the segment lines and one-hot digit-select lines of a scanned display, waits until each digit pattern is stable, and converts the pattern back into a BCD value per digit position. It sits at the board-input side of self-check and loopback setups, facing the BCD-to-7-segment driver path, and presents decoded digits, per-digit valid flags and frame/error pulses to downstream logic.

## Interface
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive synchronized cycles a pattern must hold before capture (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, active high; seg[6]=a … seg[0]=g. Asynchronous to clk.
- an  in  DIGITS  digit select, active high, one-hot when valid. Asynchronous to clk.
- bcd  out  4*DIGITS  decoded digits; digit i in bcd[4i+3:4i].
- digit_valid  out  DIGITS  digit i holds a valid decimal value.
- frame_done  out  1  one-cycle pulse when every position has been captured since the last pulse.
- pattern_err  out  1  one-cycle pulse on capture of an illegal pattern.
- err_digit  out  3  index of the digit that raised the last pattern_err; held until the next error.

## Operation
- seg and an each pass through a 2-flop synchronizer; all logic below uses the synchronized values.
- FSM states:
  - IDLE: an not one-hot (zero or multiple bits).
  - SETTLE: counting stability.
  - CAPTURED: holding after a capture.
- Transitions:
  - From any state, an not one-hot → IDLE and clear counter.
  - IDLE with an one-hot → SETTLE, counter=1.
  - SETTLE: if seg or an differs from the previous synchronized cycle → counter=1, stay. Otherwise counter+1; when counter reaches STABLE_CYCLES → capture, go to CAPTURED.
  - CAPTURED: change in seg or an (still one-hot) → SETTLE, counter=1. Recapture of the same position is allowed.
- Decode on capture, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Capture results:
  - Legal pattern: write bcd for that digit, set its digit_valid bit.
  - Blank pattern (0000000): digit_valid bit cleared, bcd unchanged, no error.
  - Any other pattern: pattern_err pulses, err_digit = index, digit_valid bit cleared, bcd unchanged.
- Frame mask:
  - Every capture (legal, blank or error) sets the position's bit in an internal frame mask.
  - When the mask becomes all ones, frame_done pulses in the same cycle as the completing capture, and the mask clears.
  - Recapturing an already-set position does not pulse.

## Timing
- Reset values: bcd=0, digit_valid=0, frame_done=0, pattern_err=0, err_digit=0, FSM=IDLE, counter=0, frame mask=0, synchronizer flops=0.
- Latency: with raw inputs stable from rising edge k, the outputs update on edge k+1+STABLE_CYCLES (2 synchronizer stages, then STABLE_CYCLES stable samples, the first of which overlaps the second synchronizer stage).
- frame_done and pattern_err are single-cycle pulses registered with the capture. Both may assert in the same cycle.
- Counter width is $clog2(STABLE_CYCLES+1) and saturates; the counter never wraps.
- Reset mid-SETTLE discards the in-progress capture. Reset is asserted asynchronously and released synchronously to clk by the system reset tree.

## Configuration
- SEG7_ALT_GLYPH_EN defined: also accept the tail-less glyphs 6=0011111 → 6 and 9=1110011 → 9 as legal.
- SEG7_ALT_GLYPH_EN undefined: those two patterns raise pattern_err like any other illegal pattern.

## Structure
- Shared package seg7_pkg holds:
  - the ten glyph constants (SEG7_GLYPH_0..9) and the two alternate glyphs;
  - the FSM state typedef (IDLE/SETTLE/CAPTURED);
  - the seg bit-order constants.
- One sub-module: seg7_glyph_decode, a combinational 7-bit → {legal, blank, bcd[3:0]} lookup that contains the SEG7_ALT_GLYPH_EN option.
- Top level holds the synchronizers, FSM, counter, digit registers and frame mask.

## Test plan
All scenarios use DIGITS=4, STABLE_CYCLES=4.
- Reset asserted mid-run with seg=1111111 → all outputs 0 and FSM IDLE, asynchronously within the same cycle.
- Scan an=0001,0010,0100,1000 with glyphs 1,2,3,4, each held 8 cycles → bcd=16'h4321, digit_valid=4'hF, one frame_done pulse on the fourth capture.
- Hold an=0001 with seg=1111110 for 3 cycles, then 1111111 for 6 cycles → no capture of 0; digit 0 = 8 at edge 5 after the change.
- an=0110 (two bits) for 10 cycles → no capture, no pulses, FSM stays IDLE.
- an=0100 with seg=1001001 held → pattern_err pulses once, err_digit=2, digit_valid[2]=0, bcd[11:8] unchanged.
- an=0001 with seg=0011111 → with SEG7_ALT_GLYPH_EN, digit 0 = 6 and valid; without it, pattern_err pulses and err_digit=0.
